fx3_wr_burst_arbiter: RTL and testbench

- Schedules the FX3 slave-FIFO write path (SLWR/ADDR/PKEND) between two streaming requesters, e.g. logic-analyzer capture and status/telemetry.
- Grants one requester at a time for whole bursts of BURST_WORDS 32-bit words, selecting a distinct GPIF socket address per requester.
- Honours the registered FX3 ready flag with the socket-switch flag latency, and terminates short packets with PKEND.
- Sits between the requester data sources (which own the DQ mux) and the FX3 pins.

---
 rtl/fx3_wr_burst_arbiter.sv | 160 ++++++++++++++++
 tb/tb_fx3_wr_burst_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx3_wr_burst_arbiter.sv
//------------------------------------------------------------------------------
// Module   : fx3_wr_burst_arbiter
// Purpose  : Round-robin burst arbiter for the FX3 slave-FIFO write path.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module fx3_wr_burst_arbiter #(
  parameter int         BURST_WORDS = 4096,
  parameter int         FLAG_LAT    = 3,
  parameter logic [1:0] SOCK0       = 2'b00,
  parameter logic [1:0] SOCK1       = 2'b01
) (
  input  logic        clk_pll,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  last,
  input  logic        flaga_d,
  output logic [1:0]  grant,
  output logic        pop,
  output logic [1:0]  addr,
  output logic        slwr_n,
  output logic        pkend_n,
  output logic        busy,
  output logic [31:0] bursts_done
);

  localparam int WCW = $clog2(BURST_WORDS) + 1;
  localparam int SCW = $clog2(FLAG_LAT + 1) + 1;
  localparam logic [WCW-1:0] C_LAST_WORD = WCW'(BURST_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARB      = 3'd1,
    S_SETTLE   = 3'd2,
    S_WAIT_RDY = 3'd3,
    S_XFER     = 3'd4,
    S_GAP      = 3'd5
  } state_t;

  state_t          r_state,  w_state;
  logic [1:0]      r_grant,  w_grant;
  logic [1:0]      r_addr,   w_addr;
  logic            r_slwr_n, w_slwr_n;
  logic            r_pkend_n, w_pkend_n;
  logic [31:0]     r_bursts_done, w_bursts_done;
  logic            r_rr,     w_rr;
  logic [WCW-1:0]  r_wcnt,   w_wcnt;
  logic [SCW-1:0]  r_scnt,   w_scnt;
  logic            w_pop;
  logic            w_win;
  logic            w_cur_req;
  logic            w_cur_last;

  assign w_cur_req  = |(req & r_grant);
  assign w_cur_last = |(last & r_grant);

  always_ff @(posedge clk_pll or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_grant       <= 2'b00;
      r_addr        <= SOCK0;
      r_slwr_n      <= 1'b1;
      r_pkend_n     <= 1'b1;
      r_bursts_done <= 32'd0;
      r_rr          <= 1'b1;
      r_wcnt        <= '0;
      r_scnt        <= '0;
    end else begin
      r_state       <= w_state;
      r_grant       <= w_grant;
      r_addr        <= w_addr;
      r_slwr_n      <= w_slwr_n;
      r_pkend_n     <= w_pkend_n;
      r_bursts_done <= w_bursts_done;
      r_rr          <= w_rr;
      r_wcnt        <= w_wcnt;
      r_scnt        <= w_scnt;
    end
  end

  always_comb begin
    w_state       = r_state;
    w_grant       = r_grant;
    w_addr        = r_addr;
    w_slwr_n      = 1'b1;
    w_pkend_n     = 1'b1;
    w_bursts_done = r_bursts_done;
    w_rr          = r_rr;
    w_wcnt        = r_wcnt;
    w_scnt        = r_scnt;
    w_pop         = 1'b0;
    w_win         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (|req) w_state = S_ARB;
      end
      S_ARB: begin
        if (req == 2'b00) begin
          w_state = S_IDLE;
        end else begin
          // On contention the requester that did not own the last burst wins.
          w_win   = (req == 2'b11) ? ~r_rr : req[1];
          w_grant = w_win ? 2'b10 : 2'b01;
          w_addr  = w_win ? SOCK1 : SOCK0;
          if (w_addr != r_addr) begin
            w_state = S_SETTLE;
            w_scnt  = SCW'(FLAG_LAT);
          end else begin
            w_state = S_WAIT_RDY;
          end
        end
      end
      S_SETTLE: begin
        w_scnt = r_scnt - SCW'(1);
        if (r_scnt <= SCW'(1)) w_state = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (flaga_d) begin
          w_wcnt  = '0;
          w_state = S_XFER;
        end
      end
      S_XFER: begin
        if (w_cur_req) begin
          w_pop    = 1'b1;
          w_slwr_n = 1'b0;
          w_wcnt   = r_wcnt + WCW'(1);
          // A full buffer commits on its own; PKEND only closes short packets.
          if (r_wcnt == C_LAST_WORD) begin
            w_state = S_GAP;
          end else if (w_cur_last) begin
            w_pkend_n = 1'b0;
            w_state   = S_GAP;
          end
        end
      end
      S_GAP: begin
        w_bursts_done = r_bursts_done + 32'd1;
        w_rr          = r_grant[1];
        w_grant       = 2'b00;
        w_state       = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign grant       = r_grant;
  assign pop         = w_pop;
  assign addr        = r_addr;
  assign slwr_n      = r_slwr_n;
  assign pkend_n     = r_pkend_n;
  assign busy        = (r_state != S_IDLE);
  assign bursts_done = r_bursts_done;

endmodule

`default_nettype wire

// File: tb/tb_fx3_wr_burst_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_fx3_wr_burst_arbiter
// Purpose  : Scoreboard bench for fx3_wr_burst_arbiter (16-word bursts).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_fx3_wr_burst_arbiter;

  localparam int         BW = 16;
  localparam int         FL = 3;
  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;

  logic        clk_pll = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  last;
  logic        flaga_d;
  logic [1:0]  grant;
  logic        pop;
  logic [1:0]  addr;
  logic        slwr_n;
  logic        pkend_n;
  logic        busy;
  logic [31:0] bursts_done;

  always #5 clk_pll = ~clk_pll;

  fx3_wr_burst_arbiter #(
    .BURST_WORDS (BW),
    .FLAG_LAT    (FL),
    .SOCK0       (S0),
    .SOCK1       (S1)
  ) dut (
    .clk_pll     (clk_pll),
    .reset       (reset),
    .req         (req),
    .last        (last),
    .flaga_d     (flaga_d),
    .grant       (grant),
    .pop         (pop),
    .addr        (addr),
    .slwr_n      (slwr_n),
    .pkend_n     (pkend_n),
    .busy        (busy),
    .bursts_done (bursts_done)
  );

  typedef struct {
    logic [1:0] g;
    int         words;
    int         pk;
    int         pkpos;
    logic [1:0] a;
    int         lat;
    int         holes;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_bd   = 0;

  // Requester models: stream length, words consumed, last position, stall point.
  int s_len[2], s_cons[2], s_last[2], s_stall_at[2], s_stall_left[2];

  // Per-burst observations gathered at the falling edge.
  int          m_words, m_pops, m_pk, m_pkpos, m_lat, m_holes;
  logic        m_seen;
  logic [1:0]  m_g, m_a;
  logic [31:0] m_bd_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  task automatic clear_mon();
    m_words = 0; m_pops = 0; m_pk = 0; m_pkpos = 0;
    m_lat = 0; m_holes = 0; m_seen = 1'b0; m_g = 2'b00; m_a = 2'b00;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < 2; i++) begin
      req[i]  = (s_cons[i] < s_len[i]) && (s_stall_left[i] == 0);
      last[i] = req[i] && (s_last[i] != 0) && (s_cons[i] + 1 == s_last[i]);
    end
  endtask

  task automatic start_stream(input int i, input int len, input int last_at, input int stall_at);
    s_len[i] = len; s_cons[i] = 0; s_last[i] = last_at;
    s_stall_at[i] = stall_at; s_stall_left[i] = 0;
    drive_reqs();
  endtask

  task automatic expect_burst(input logic [1:0] g, input int words, input int pk,
                              input int pkpos, input logic [1:0] a, input int lat,
                              input int holes);
    exp_t e;
    e.g = g; e.words = words; e.pk = pk; e.pkpos = pkpos;
    e.a = a; e.lat = lat; e.holes = holes;
    sb.push_back(e);
  endtask

  task automatic score();
    exp_t e;
    if (sb.size() == 0) begin
      check("burst_unexpected", bursts_done, exp_bd);
    end else begin
      e = sb.pop_front();
      exp_bd++;
      check("bursts_done", bursts_done, exp_bd);
      check("words",       m_words, e.words);
      check("pops",        m_pops,  e.words);
      check("grant",       m_g,     e.g);
      check("addr",        m_a,     e.a);
      check("pkend_cnt",   m_pk,    e.pk);
      check("pkend_pos",   m_pkpos, e.pkpos);
      check("stall_holes", m_holes, e.holes);
      if (e.lat != 0) check("latency", m_lat, e.lat);
    end
    clear_mon();
  endtask

  task automatic monitor();
    if (pop) m_pops++;
    if (!slwr_n) begin
      m_words++;
      if (!m_seen) begin
        m_seen = 1'b1; m_g = grant; m_a = addr;
      end
    end else if (busy) begin
      if (m_seen) m_holes++;
      else        m_lat++;
    end
    if (!pkend_n) begin
      m_pk++;
      m_pkpos = slwr_n ? 99 : m_words;
    end
    if (bursts_done != m_bd_prev) begin
      m_bd_prev = bursts_done;
      score();
    end
  endtask

  // One clock: observe at the falling edge, update requesters after the rising edge.
  task automatic step();
    logic       p;
    logic [1:0] g;
    @(negedge clk_pll);
    monitor();
    p = pop;
    g = grant;
    @(posedge clk_pll);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (s_stall_left[i] > 0) s_stall_left[i]--;
      if (p && g[i]) begin
        s_cons[i]++;
        if (s_cons[i] == s_stall_at[i]) s_stall_left[i] = 4;
      end
    end
    drive_reqs();
  endtask

  task automatic run_until_idle(input int maxc);
    int k = 0;
    while ((sb.size() != 0 || busy) && k < maxc) begin
      step();
      k++;
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    reset = 1'b1; req = 2'b00; last = 2'b00; flaga_d = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_len[i] = 0; s_cons[i] = 0; s_last[i] = 0; s_stall_at[i] = 0; s_stall_left[i] = 0;
    end
    clear_mon();
    m_bd_prev = 32'd0;
    repeat (2) @(posedge clk_pll);
    #1;
    check("rst_grant",   grant,       2'b00);
    check("rst_pop",     pop,         1'b0);
    check("rst_addr",    addr,        S0);
    check("rst_slwr_n",  slwr_n,      1'b1);
    check("rst_pkend_n", pkend_n,     1'b1);
    check("rst_busy",    busy,        1'b0);
    check("rst_bursts",  bursts_done, 32'd0);
    @(posedge clk_pll);
    #1 reset = 1'b0;
    flaga_d = 1'b1;

    // Full burst on requester 0, socket already selected.
    start_stream(0, BW, 0, 0);
    expect_burst(2'b01, BW, 0, 0, S0, 3, 0);
    run_until_idle(200);

    // Short packet closed on word 5.
    start_stream(0, 5, 5, 0);
    expect_burst(2'b01, 5, 1, 5, S0, 3, 0);
    run_until_idle(200);

    // last on the final word of a full buffer: no PKEND.
    start_stream(0, BW, BW, 0);
    expect_burst(2'b01, BW, 0, 0, S0, 3, 0);
    run_until_idle(200);

    // Ready flag held low for 20 cycles.
    flaga_d = 1'b0;
    start_stream(0, BW, 0, 0);
    expect_burst(2'b01, BW, 0, 0, S0, 21, 0);
    repeat (20) step();
    check("flag_lo_words", m_words, 0);
    check("flag_lo_pops",  m_pops,  0);
    check("flag_lo_grant", grant,   2'b01);
    check("flag_lo_busy",  busy,    1'b1);
    flaga_d = 1'b1;
    run_until_idle(200);

    // Requester stalls for 4 cycles after word 7.
    start_stream(0, BW, 0, 7);
    expect_burst(2'b01, BW, 0, 0, S0, 3, 4);
    run_until_idle(200);

    // Reset in the middle of a requester 1 burst.
    start_stream(1, BW, 0, 0);
    begin
      int k = 0;
      while (s_cons[1] < 7 && k < 200) begin
        step();
        k++;
      end
    end
    check("mid_words_before_rst", s_cons[1], 7);
    reset = 1'b1;
    #1;
    check("mid_rst_slwr_n",  slwr_n,      1'b1);
    check("mid_rst_pkend_n", pkend_n,     1'b1);
    check("mid_rst_grant",   grant,       2'b00);
    check("mid_rst_busy",    busy,        1'b0);
    check("mid_rst_addr",    addr,        S0);
    check("mid_rst_bursts",  bursts_done, 32'd0);
    exp_bd = 0;
    m_bd_prev = 32'd0;
    clear_mon();
    @(posedge clk_pll);
    #1 reset = 1'b0;
    start_stream(1, BW, 0, 0);
    expect_burst(2'b10, BW, 0, 0, S1, 6, 0);
    run_until_idle(200);
    check("post_rst_bursts", bursts_done, 32'd1);

    // Both requesting: grants alternate, each socket switch settles first.
    start_stream(0, 2 * BW, 0, 0);
    start_stream(1, 2 * BW, 0, 0);
    expect_burst(2'b01, BW, 0, 0, S0, 6, 0);
    expect_burst(2'b10, BW, 0, 0, S1, 6, 0);
    expect_burst(2'b01, BW, 0, 0, S0, 6, 0);
    expect_burst(2'b10, BW, 0, 0, S1, 6, 0);
    run_until_idle(400);
    check("final_bursts", bursts_done, 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
